// File: rtl/cdr_pkg.sv
// Shared helpers and constants for the oversampling CDR (cdr_os4).
// The CDR_LOCK_DETECT_EN build option uses the window helpers below.
package cdr_pkg;

  localparam int OS_NOM = 4;

  function automatic int phase_w(input int os);
    return (os > 1) ? $clog2(os) : 1;
  endfunction

  function automatic int sample_ph(input int os);
    return os / 2;
  endfunction

  // Lock window spans one phase either side of the re-alignment point.
  function automatic int win_early(input int os);
    return os - 1;
  endfunction

  localparam int WIN_LATE = 1;

  typedef logic [phase_w(OS_NOM)-1:0] phase_t;

  localparam phase_t SAMPLE_PH = phase_t'(sample_ph(OS_NOM));

endpackage

// File: rtl/cdr_sync.sv
// Two-flop synchroniser for the asynchronous serial input plus an edge
// detector comparing the synchronised bit against its previous value.
module cdr_sync (
  input  logic clk,
  input  logic reset,
  input  logic data_in,
  output logic s2,
  output logic edge_det
);

  logic s1_r;
  logic s2_r;
  logic prev_r;

  // synchroniser chain and one-cycle history for transition detection
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_r   <= 1'b0;
      s2_r   <= 1'b0;
      prev_r <= 1'b0;
    end else begin
      s1_r   <= data_in;
      s2_r   <= s1_r;
      prev_r <= s2_r;
    end
  end

  assign s2       = s2_r;
  assign edge_det = s2_r ^ prev_r;

endmodule

// File: rtl/cdr_os4.sv
// Oversampling clock-and-data recovery: re-aligns a phase counter on every
// data transition and samples mid-bit. Optional lock detector: CDR_LOCK_DETECT_EN.
module cdr_os4
  import cdr_pkg::*;
#(
  parameter int OS = 4
`ifdef CDR_LOCK_DETECT_EN
  , parameter int LOCK_EDGES = 8
`endif
) (
  input  logic clk,
  input  logic reset,
  input  logic data_in,
  output logic clk_out,
  output logic data_out,
  output logic sample_stb
`ifdef CDR_LOCK_DETECT_EN
  , output logic locked
`endif
);

  localparam int PW = phase_w(OS);
  localparam logic [PW-1:0] PH_ZERO   = PW'(0);
  localparam logic [PW-1:0] PH_ONE    = PW'(1);
  localparam logic [PW-1:0] PH_LAST   = PW'(OS - 1);
  localparam logic [PW-1:0] PH_SAMPLE = PW'(sample_ph(OS));

  logic          s2_s;
  logic          edge_s;
  logic          take_s;
  logic [PW-1:0] ph_r;
  logic          data_out_r;
  logic          clk_out_r;
  logic          sample_stb_r;

  cdr_sync u_sync (
    .clk      (clk),
    .reset    (reset),
    .data_in  (data_in),
    .s2       (s2_s),
    .edge_det (edge_s)
  );

  // A transition in the sample slot means the bit boundary moved: skip it.
  assign take_s = !edge_s && (ph_r == PH_SAMPLE);

  // phase tracking, mid-bit sampling and recovered clock generation
  always_ff @(posedge clk) begin
    if (reset) begin
      ph_r         <= PH_ZERO;
      data_out_r   <= 1'b0;
      clk_out_r    <= 1'b0;
      sample_stb_r <= 1'b0;
    end else begin
      if (edge_s) begin
        ph_r <= PH_ONE;
      end else if (ph_r == PH_LAST) begin
        ph_r <= PH_ZERO;
      end else begin
        ph_r <= ph_r + PH_ONE;
      end
      sample_stb_r <= take_s;
      if (take_s) begin
        data_out_r <= s2_s;
        clk_out_r  <= 1'b1;
      end else if (edge_s || (ph_r == PH_ZERO)) begin
        clk_out_r  <= 1'b0;
      end else begin
        clk_out_r  <= clk_out_r;
      end
    end
  end

  assign data_out   = data_out_r;
  assign clk_out    = clk_out_r;
  assign sample_stb = sample_stb_r;

`ifdef CDR_LOCK_DETECT_EN
  localparam int LW = $clog2(LOCK_EDGES + 1);
  localparam logic [LW-1:0] LOCK_MAX  = LW'(LOCK_EDGES);
  localparam logic [LW-1:0] LOCK_NEAR = LW'(LOCK_EDGES - 1);
  localparam logic [PW-1:0] PH_WIN_E  = PW'(win_early(OS));
  localparam logic [PW-1:0] PH_WIN_L  = PW'(WIN_LATE);

  logic [LW-1:0] lock_cnt_r;
  logic          locked_r;
  logic          in_win_s;

  assign in_win_s = (ph_r == PH_WIN_E) || (ph_r == PH_ZERO) || (ph_r == PH_WIN_L);

  // count consecutive in-window edges; any late or early edge drops lock
  always_ff @(posedge clk) begin
    if (reset) begin
      lock_cnt_r <= LW'(0);
      locked_r   <= 1'b0;
    end else if (edge_s) begin
      if (in_win_s) begin
        if (lock_cnt_r != LOCK_MAX) begin
          lock_cnt_r <= lock_cnt_r + LW'(1);
        end else begin
          lock_cnt_r <= lock_cnt_r;
        end
        if (lock_cnt_r >= LOCK_NEAR) begin
          locked_r <= 1'b1;
        end else begin
          locked_r <= locked_r;
        end
      end else begin
        lock_cnt_r <= LW'(0);
        locked_r   <= 1'b0;
      end
    end else begin
      lock_cnt_r <= lock_cnt_r;
      locked_r   <= locked_r;
    end
  end

  assign locked = locked_r;
`endif

endmodule

// File: tb/tb_cdr_os4.sv
// Self-checking bench for cdr_os4 (OS=4): directed scenarios plus randomised
// run lengths and bit periods, checked against a cycle-level reference model.
module tb_cdr_os4;

  localparam int OS         = 4;
  localparam int LOCK_EDGES = 8;

  logic clk     = 1'b0;
  logic reset   = 1'b1;
  logic data_in = 1'b0;
  logic clk_out;
  logic data_out;
  logic sample_stb;
`ifdef CDR_LOCK_DETECT_EN
  logic locked;
`endif

  int total = 0;
  int bad   = 0;

  // reference model state: input history, phase since last edge/reset
  int   cyc      = 0;
  int   lastref  = 0;
  int   p_c      = 0;
  int   lock_cnt = 0;
  logic d_c = 1'b0, d_c1 = 1'b0, d_c2 = 1'b0, edge_c = 1'b0;
  logic e_do = 1'b0, e_co = 1'b0, e_stb = 1'b0, e_lk = 1'b0;

  cdr_os4 dut (
    .clk        (clk),
    .reset      (reset),
    .data_in    (data_in),
    .clk_out    (clk_out),
    .data_out   (data_out),
    .sample_stb (sample_stb)
`ifdef CDR_LOCK_DETECT_EN
    , .locked   (locked)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic act_lk();
`ifdef CDR_LOCK_DETECT_EN
    return locked;
`else
    return 1'b0;
`endif
  endfunction

  // One clock: drive inputs, advance the model, settle past the edge.
  task automatic tick(input logic din, input logic rst);
    logic edge_p;
    logic s2_p;
    int   p_p;
    edge_p  = edge_c;
    p_p     = p_c;
    s2_p    = d_c1;
    data_in = din;
    reset   = rst;
    @(posedge clk);
    cyc++;
    if (rst) begin
      d_c = 1'b0; d_c1 = 1'b0; d_c2 = 1'b0; edge_c = 1'b0;
      p_c = 0; lastref = cyc; lock_cnt = 0;
      e_do = 1'b0; e_co = 1'b0; e_stb = 1'b0; e_lk = 1'b0;
    end else begin
      e_stb = !edge_p && (p_p == OS / 2);
      if (e_stb) begin
        e_do = s2_p;
        e_co = 1'b1;
      end else if (edge_p || p_p == 0) begin
        e_co = 1'b0;
      end
`ifdef CDR_LOCK_DETECT_EN
      if (edge_p) begin
        if (p_p == OS - 1 || p_p == 0 || p_p == 1) begin
          if (lock_cnt < LOCK_EDGES) lock_cnt++;
          if (lock_cnt == LOCK_EDGES) e_lk = 1'b1;
        end else begin
          lock_cnt = 0;
          e_lk = 1'b0;
        end
      end
`endif
      if (edge_p) lastref = cyc - 1;
      p_c = (cyc - lastref) % OS;
      d_c2 = d_c1; d_c1 = d_c; d_c = din;
      edge_c = d_c1 ^ d_c2;
    end
    #1;
  endtask

  task automatic test_reset();
    int stb_n = 0;
    for (int i = 0; i < 3; i++) begin
      tick((i % 2 == 0) ? 1'b1 : 1'b0, 1'b1);
      total++;
      if ({data_out, clk_out, sample_stb, act_lk()} !== 4'b0000) begin
        bad++;
        $display("FAIL reset_hold cyc=%0d got=%b want=0000", cyc,
                 {data_out, clk_out, sample_stb, act_lk()});
      end
    end
    for (int i = 0; i < 8; i++) begin
      tick(1'b0, 1'b0);
      if (sample_stb) stb_n++;
      total++;
      if ({data_out, clk_out, sample_stb, act_lk()} !== {e_do, e_co, e_stb, e_lk}) begin
        bad++;
        $display("FAIL reset_idle cyc=%0d got=%b want=%b", cyc,
                 {data_out, clk_out, sample_stb, act_lk()}, {e_do, e_co, e_stb, e_lk});
      end
    end
    total++;
    if (stb_n !== 2) begin
      bad++;
      $display("FAIL idle_strobes got=%0d want=2", stb_n);
    end
  endtask

  task automatic test_alternating();
    int   stb_n = 0;
    int   hi_n  = 0;
    int   seen  = 0;
    logic last_v = 1'b0;
    for (int t = 1; t <= 24; t++) begin
      tick((((t - 1) / 4) % 2 == 0) ? 1'b1 : 1'b0, 1'b0);
      total++;
      if ({data_out, clk_out, sample_stb} !== {e_do, e_co, e_stb}) begin
        bad++;
        $display("FAIL alt_model cyc=%0d got=%b want=%b", cyc,
                 {data_out, clk_out, sample_stb}, {e_do, e_co, e_stb});
      end
      if (t == 4 || t == 5) begin
        total++;
        if (data_out !== (t == 5)) begin
          bad++;
          $display("FAIL alt_latency t=%0d got=%b want=%b", t, data_out, (t == 5));
        end
      end
      if (t > 12) begin
        if (sample_stb) stb_n++;
        if (clk_out) hi_n++;
      end
      if (sample_stb && t > 5) begin
        if (seen > 0) begin
          total++;
          if (data_out === last_v) begin
            bad++;
            $display("FAIL alt_toggle t=%0d got=%b want=%b", t, data_out, !last_v);
          end
        end
        last_v = data_out;
        seen++;
      end
    end
    total++;
    if (stb_n !== 3 || hi_n !== 6) begin
      bad++;
      $display("FAIL alt_duty strobes=%0d want=3 clk_hi=%0d want=6", stb_n, hi_n);
    end
  endtask

  task automatic test_long_run();
    int stb_n  = 0;
    int zero_n = 0;
    for (int t = 1; t <= 20; t++) begin
      tick(1'b1, 1'b0);
      if (sample_stb) stb_n++;
      if (t >= 5 && data_out !== 1'b1) zero_n++;
      total++;
      if ({data_out, clk_out, sample_stb} !== {e_do, e_co, e_stb}) begin
        bad++;
        $display("FAIL run_model cyc=%0d got=%b want=%b", cyc,
                 {data_out, clk_out, sample_stb}, {e_do, e_co, e_stb});
      end
    end
    total++;
    if (stb_n !== 5 || zero_n !== 0) begin
      bad++;
      $display("FAIL run_strobes strobes=%0d want=5 non_one=%0d want=0", stb_n, zero_n);
    end
  endtask

  task automatic test_fast_drift();
    logic v0     = data_in;
    logic prev_o = data_out;
    int   trans  = 0;
    int   dups   = 0;
    int   n;
    for (int k = 0; k < 200; k++) begin
      n = (k == 0) ? 0 : ((10 * k - 4) / 38) + 1;
      if (n > 50) n = 50;
      tick(v0 ^ n[0], 1'b0);
      if (data_out !== prev_o) trans++;
      if (sample_stb && data_out === prev_o && k >= 12 && k <= 185) dups++;
      prev_o = data_out;
      total++;
      if ({data_out, clk_out, sample_stb} !== {e_do, e_co, e_stb}) begin
        bad++;
        $display("FAIL drift_model cyc=%0d got=%b want=%b", cyc,
                 {data_out, clk_out, sample_stb}, {e_do, e_co, e_stb});
      end
    end
    total++;
    if (trans !== 50 || dups !== 0) begin
      bad++;
      $display("FAIL drift_bits transitions=%0d want=50 dups=%0d want=0", trans, dups);
    end
  endtask

  task automatic test_random();
    logic lvl = data_in;
    int   n;
    int   p10;
    int   dur;
    for (int r = 0; r < 40; r++) begin
      lvl = !lvl;
      n   = $urandom_range(5, 1);
      p10 = $urandom_range(42, 38);
      dur = (n * p10 + 5) / 10;
      for (int c = 0; c < dur; c++) begin
        tick(lvl, 1'b0);
        total++;
        if ({data_out, clk_out, sample_stb, act_lk()} !== {e_do, e_co, e_stb, e_lk}) begin
          bad++;
          $display("FAIL rand_model cyc=%0d got=%b want=%b", cyc,
                   {data_out, clk_out, sample_stb, act_lk()}, {e_do, e_co, e_stb, e_lk});
        end
      end
    end
  endtask

`ifdef CDR_LOCK_DETECT_EN
  task automatic test_lock();
    tick(1'b0, 1'b1);
    for (int t = 0; t < 4 + 40 + 6; t++) begin
      if (t < 4) tick(1'b0, 1'b0);
      else if (t < 44) tick((((t - 4) / 4) % 2 == 0) ? 1'b1 : 1'b0, 1'b0);
      else tick((t < 46) ? 1'b1 : 1'b0, 1'b0);
      total++;
      if ({data_out, clk_out, sample_stb, locked} !== {e_do, e_co, e_stb, e_lk}) begin
        bad++;
        $display("FAIL lock_model cyc=%0d got=%b want=%b", cyc,
                 {data_out, clk_out, sample_stb, locked}, {e_do, e_co, e_stb, e_lk});
      end
      if (t == 43 || t == 49) begin
        total++;
        if (locked !== (t == 43)) begin
          bad++;
          $display("FAIL lock_state t=%0d got=%b want=%b", t, locked, (t == 43));
        end
      end
    end
  endtask
`endif

  task automatic test_reset_mid();
    for (int t = 0; t < 50; t++) begin
      tick(((t / 4) % 2 == 0) ? 1'b1 : 1'b0, (t == 13));
      if (t == 13) begin
        total++;
        if ({data_out, clk_out, sample_stb, act_lk()} !== 4'b0000) begin
          bad++;
          $display("FAIL mid_reset got=%b want=0000", {data_out, clk_out, sample_stb, act_lk()});
        end
      end
      total++;
      if ({data_out, clk_out, sample_stb, act_lk()} !== {e_do, e_co, e_stb, e_lk}) begin
        bad++;
        $display("FAIL mid_model cyc=%0d got=%b want=%b", cyc,
                 {data_out, clk_out, sample_stb, act_lk()}, {e_do, e_co, e_stb, e_lk});
      end
      if (t >= 26 && sample_stb) begin
        total++;
        if (data_out !== ((((t - 4) / 4) % 2 == 0) ? 1'b1 : 1'b0)) begin
          bad++;
          $display("FAIL mid_recover t=%0d got=%b want=%b", t, data_out,
                   ((((t - 4) / 4) % 2 == 0) ? 1'b1 : 1'b0));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_alternating();
    test_long_run();
    test_fast_drift();
    test_random();
`ifdef CDR_LOCK_DETECT_EN
    test_lock();
`endif
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
